// File: rtl/ddr2_interface_local_port_arbiter_if.sv
// rtl/ddr2_interface_local_port_arbiter_if.sv - local-port and controller-side bus bundle for the port arbiter
interface ddr2_interface_local_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int SIZE_W    = 3
);
  // user-side per-port command bus
  logic [NUM_PORTS*ADDR_W-1:0] port_address;
  logic [NUM_PORTS-1:0]        port_read_req;
  logic [NUM_PORTS-1:0]        port_write_req;
  logic [NUM_PORTS-1:0]        port_burstbegin;
  logic [NUM_PORTS*SIZE_W-1:0] port_size;
  logic [NUM_PORTS*DATA_W-1:0] port_wdata;
  logic [NUM_PORTS*BE_W-1:0]   port_be;
  logic [NUM_PORTS-1:0]        port_ready;
  logic [DATA_W-1:0]           port_rdata;
  logic [NUM_PORTS-1:0]        port_rdata_valid;

  // controller-side single local port
  logic [ADDR_W-1:0]           local_address;
  logic                        local_read_req;
  logic                        local_write_req;
  logic                        local_burstbegin;
  logic [SIZE_W-1:0]           local_size;
  logic [DATA_W-1:0]           local_wdata;
  logic [BE_W-1:0]             local_be;
  logic                        local_ready;
  logic [DATA_W-1:0]           local_rdata;
  logic                        local_rdata_valid;

  // arbiter view
  modport slave (
    input  port_address, port_read_req, port_write_req, port_burstbegin, port_size,
           port_wdata, port_be, local_ready, local_rdata, local_rdata_valid,
    output port_ready, port_rdata, port_rdata_valid, local_address, local_read_req,
           local_write_req, local_burstbegin, local_size, local_wdata, local_be
  );

  // user logic plus controller view
  modport master (
    output port_address, port_read_req, port_write_req, port_burstbegin, port_size,
           port_wdata, port_be, local_ready, local_rdata, local_rdata_valid,
    input  port_ready, port_rdata, port_rdata_valid, local_address, local_read_req,
           local_write_req, local_burstbegin, local_size, local_wdata, local_be
  );
endinterface

// File: rtl/ddr2_interface_local_port_arbiter.sv
// rtl/ddr2_interface_local_port_arbiter.sv - round-robin N-port arbiter with write-burst lock and in-order read tag FIFO
module ddr2_interface_local_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int SIZE_W    = 3,
  parameter int TAG_DEPTH = 16
) (
  input  logic phy_clk,
  input  logic reset_phy_clk_n,
  ddr2_interface_local_port_arbiter_if.slave bus,
  output logic tag_full,
  output logic err_size,
  output logic err_orphan
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = GW + SIZE_W;

  typedef enum logic [1:0] {IDLE, GRANT, WBURST} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt, last_grant, last_grant_nxt;
  logic [SIZE_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [SIZE_W-1:0] g_size, g_eff_size;
  logic              g_rd, g_wr, push, pop, size_err_set;

  logic [TW-1:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [SIZE_W-1:0] rcnt, rcnt_nxt;
  logic [TW-1:0]     head;
  logic [GW-1:0]     head_p;
  logic [SIZE_W-1:0] head_n;

  assign g_rd       = bus.port_read_req[grant];
  assign g_wr       = bus.port_write_req[grant];
  assign g_size     = bus.port_size[int'(grant)*SIZE_W +: SIZE_W];
  assign g_eff_size = (g_size == '0) ? SIZE_W'(1) : g_size;
  assign head       = tag_mem[rd_ptr];
  assign head_p     = head[TW-1:SIZE_W];
  assign head_n     = head[SIZE_W-1:0];

  // Arbitration state register
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Next-state, round-robin pick and command mux toward the controller
  always_comb begin
    int   idx;
    logic found;
    idx              = 0;
    found            = 1'b0;
    state_nxt        = state;
    grant_nxt        = grant;
    last_grant_nxt   = last_grant;
    beat_cnt_nxt     = beat_cnt;
    push             = 1'b0;
    size_err_set     = 1'b0;
    bus.port_ready       = '0;
    bus.local_address    = '0;
    bus.local_read_req   = 1'b0;
    bus.local_write_req  = 1'b0;
    bus.local_burstbegin = 1'b0;
    bus.local_size       = '0;
    bus.local_wdata      = '0;
    bus.local_be         = '0;
    if (state != IDLE) begin
      bus.local_address = bus.port_address[int'(grant)*ADDR_W +: ADDR_W];
      bus.local_size    = g_size;
      bus.local_wdata   = bus.port_wdata[int'(grant)*DATA_W +: DATA_W];
      bus.local_be      = bus.port_be[int'(grant)*BE_W +: BE_W];
    end
    case (state)
      IDLE: begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = (int'(last_grant) + k) % NUM_PORTS;
          if (!found && (bus.port_read_req[idx] || bus.port_write_req[idx])) begin
            found     = 1'b1;
            grant_nxt = GW'(idx);
          end
        end
        if (found) state_nxt = GRANT;
      end
      GRANT: begin
        // write wins over a simultaneous read; reads are held off while tags are full
        bus.local_write_req   = g_wr;
        bus.local_read_req    = g_rd && !g_wr && !tag_full;
        bus.local_burstbegin  = bus.port_burstbegin[grant];
        bus.port_ready[grant] = bus.local_ready && !(g_rd && !g_wr && tag_full);
        if (bus.local_ready && g_wr) begin
          size_err_set = (g_size == '0);
          if (g_eff_size == SIZE_W'(1)) begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else begin
            beat_cnt_nxt = g_eff_size - SIZE_W'(1);
            state_nxt    = WBURST;
          end
        end else if (bus.local_ready && g_rd && !tag_full) begin
          push           = 1'b1;
          size_err_set   = (g_size == '0);
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end else if (!g_rd && !g_wr) begin
          state_nxt = IDLE;
        end
      end
      WBURST: begin
        bus.local_write_req   = g_wr;
        bus.port_ready[grant] = bus.local_ready;
        if (bus.local_ready && g_wr) begin
          if (beat_cnt == SIZE_W'(1)) begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt - SIZE_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read return routing: head tag selects the destination port, counting beats
  always_comb begin
    bus.port_rdata       = bus.local_rdata;
    bus.port_rdata_valid = '0;
    pop                  = 1'b0;
    rcnt_nxt             = rcnt;
    if (bus.local_rdata_valid && count != '0) begin
      bus.port_rdata_valid[head_p] = 1'b1;
      if (rcnt + SIZE_W'(1) == head_n) begin
        pop      = 1'b1;
        rcnt_nxt = '0;
      end else begin
        rcnt_nxt = rcnt + SIZE_W'(1);
      end
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // Tag storage carries no reset; validity is tracked by pointers and count
  always_ff @(posedge phy_clk) begin
    if (push) tag_mem[wr_ptr] <= {grant, g_eff_size};
  end

  // Tag FIFO pointers, occupancy, return counter and registered full flag
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rcnt     <= '0;
      tag_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      rcnt     <= rcnt_nxt;
      tag_full <= (count_nxt == CW'(TAG_DEPTH));
    end
  end

  // Sticky error flags
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      err_size   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (size_err_set) err_size <= 1'b1;
      if (bus.local_rdata_valid && count == '0) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr2_interface_local_port_arbiter.sv
// tb/tb_ddr2_interface_local_port_arbiter.sv - scoreboard bench for the DDR2 local port arbiter
module tb_ddr2_interface_local_port_arbiter;
  logic clk;
  logic rst_n;
  logic tag_full, err_size, err_orphan;
  int   n_run;
  int   n_fail;
  int   exp_q[$];
  int   fair_exp [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
  int   wb_lr    [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
  int   wb_rdy   [8] = '{0, 1, 1, 0, 1, 1, 0, 2};
  int   wb_bb    [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  int   wb_wr    [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
  int   w;
  int   p;

  ddr2_interface_local_port_arbiter_if #(
    .NUM_PORTS(2), .ADDR_W(25), .DATA_W(32), .BE_W(4), .SIZE_W(3)
  ) bus ();

  ddr2_interface_local_port_arbiter #(
    .NUM_PORTS(2), .ADDR_W(25), .DATA_W(32), .BE_W(4), .SIZE_W(3), .TAG_DEPTH(4)
  ) dut (
    .phy_clk         (clk),
    .reset_phy_clk_n (rst_n),
    .bus             (bus.slave),
    .tag_full        (tag_full),
    .err_size        (err_size),
    .err_orphan      (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int pi, input bit rd, input bit wr, input bit bb,
                         input logic [24:0] addr, input logic [2:0] sz, input logic [31:0] wd);
    bus.port_read_req[pi]          = rd;
    bus.port_write_req[pi]         = wr;
    bus.port_burstbegin[pi]        = bb;
    bus.port_address[pi*25 +: 25]  = addr;
    bus.port_size[pi*3 +: 3]       = sz;
    bus.port_wdata[pi*32 +: 32]    = wd;
    bus.port_be[pi*4 +: 4]         = 4'hf;
  endtask

  task automatic do_read(input int pi, input logic [24:0] addr, input logic [2:0] sz, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    set_cmd(pi, 1, 0, 0, addr, sz, 32'h0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.port_ready[pi]) begin
        chk("rd_addr", bus.local_address, addr);
        chk("rd_size", bus.local_size, sz);
        for (int b = 0; b < sz; b++) exp_q.push_back(pi);
        tick();
        set_cmd(pi, 0, 0, 0, 25'h0, 3'h0, 32'h0);
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    chk("rd_accepted", ok, 1);
  endtask

  task automatic ret_beat(input string tag);
    logic [31:0] d;
    int          ep;
    d = $urandom;
    bus.local_rdata_valid = 1'b1;
    bus.local_rdata       = d;
    #1;
    chk({tag, "_have_exp"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      ep = exp_q.pop_front();
      chk(tag, bus.port_rdata_valid, 2'b01 << ep);
      chk({tag, "_data"}, bus.port_rdata, d);
    end
    tick();
    bus.local_rdata_valid = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    bus.port_address = '0; bus.port_read_req = '0; bus.port_write_req = '0;
    bus.port_burstbegin = '0; bus.port_size = '0; bus.port_wdata = '0; bus.port_be = '0;
    bus.local_ready = 1'b1; bus.local_rdata = '0; bus.local_rdata_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lrd", bus.local_read_req, 0);
    chk("rst_lwr", bus.local_write_req, 0);
    chk("rst_addr", bus.local_address, 0);
    chk("rst_rdy", bus.port_ready, 0);
    chk("rst_full", tag_full, 0);
    chk("rst_errs", {err_size, err_orphan}, 0);
    rst_n = 1'b1;
    tick();

    // single read, port 1, 4 beats
    do_read(1, 25'h100, 3'd4, w);
    chk("rd_latency", w, 1);
    for (int b = 0; b < 4; b++) ret_beat("ret_single");
    #1;
    chk("rv_idle", bus.port_rdata_valid, 0);
    tick();

    // fairness: both ports read continuously; fills the 4-deep tag FIFO
    set_cmd(0, 1, 0, 0, 25'h10, 3'd1, 32'h0);
    set_cmd(1, 1, 0, 0, 25'h20, 3'd1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_rdy", bus.port_ready, fair_exp[i]);
      chk("fair_lrd", bus.local_read_req, i % 2);
      if (fair_exp[i] != 0) exp_q.push_back(fair_exp[i] == 2 ? 1 : 0);
      tick();
    end
    set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    set_cmd(1, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    #1;
    chk("tag_full_4", tag_full, 1);
    tick();

    // fifth read stalls until one return frees a slot
    set_cmd(0, 1, 0, 0, 25'h30, 3'd1, 32'h0);
    tick();
    #1;
    chk("full_stall_rdy", bus.port_ready, 0);
    chk("full_stall_lrd", bus.local_read_req, 0);
    tick();
    ret_beat("ret_free");
    #1;
    chk("fifth_rdy", bus.port_ready, 1);
    exp_q.push_back(0);
    tick();
    set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    for (int b = 0; b < 4; b++) ret_beat("ret_fair");

    // interleaved returns with push and pop in the same cycle
    do_read(0, 25'h40, 3'd2, w);
    set_cmd(1, 1, 0, 0, 25'h50, 3'd3, 32'h0);
    ret_beat("ret_il");
    for (int b = 0; b < 3; b++) exp_q.push_back(1);
    bus.local_rdata_valid = 1'b1;
    bus.local_rdata       = 32'ha5a5_0001;
    #1;
    chk("il_push_rdy", bus.port_ready, 2);
    p = exp_q.pop_front();
    chk("il_pop_rv", bus.port_rdata_valid, 2'b01 << p);
    tick();
    bus.local_rdata_valid = 1'b0;
    set_cmd(1, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    for (int b = 0; b < 3; b++) ret_beat("ret_il");
    #1;
    chk("il_no_orphan", err_orphan, 0);
    chk("il_not_full", tag_full, 0);
    tick();

    // write burst lock with a mid-burst stall; port 1 waits
    set_cmd(0, 0, 1, 1, 25'h60, 3'd4, 32'hdead_beef);
    set_cmd(1, 1, 0, 0, 25'h70, 3'd1, 32'h0);
    tick();
    for (int i = 1; i < 8; i++) begin
      bus.local_ready = wb_lr[i][0];
      if (i == 6) set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
      #1;
      chk("wb_rdy", bus.port_ready, wb_rdy[i]);
      chk("wb_bb", bus.local_burstbegin, wb_bb[i]);
      chk("wb_wr", bus.local_write_req, wb_wr[i]);
      if (i == 1) chk("wb_wdata", bus.local_wdata, 32'hdead_beef);
      if (i == 7) begin
        chk("wb_p1_lrd", bus.local_read_req, 1);
        exp_q.push_back(1);
      end
      tick();
    end
    bus.local_ready = 1'b1;
    set_cmd(1, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    ret_beat("ret_wb");

    // size-0 write counts as one beat and flags err_size
    #1;
    chk("err_size_pre", err_size, 0);
    tick();
    set_cmd(0, 0, 1, 1, 25'h80, 3'd0, 32'h1234_5678);
    tick();
    #1;
    chk("sz0_rdy", bus.port_ready, 1);
    chk("sz0_lsize", bus.local_size, 0);
    tick();
    set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    #1;
    chk("sz0_err", err_size, 1);
    chk("sz0_idle_rdy", bus.port_ready, 0);
    tick();

    // reset in WBURST, then a stray return
    set_cmd(0, 0, 1, 1, 25'h90, 3'd4, 32'h0);
    tick();
    tick();
    #1;
    chk("pre_rst_wb", bus.local_write_req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_lwr", bus.local_write_req, 0);
    chk("arst_rdy", bus.port_ready, 0);
    chk("arst_err_size", err_size, 0);
    set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.local_rdata_valid = 1'b1;
    #1;
    chk("orph_rv", bus.port_rdata_valid, 0);
    tick();
    bus.local_rdata_valid = 1'b0;
    #1;
    chk("orph_err", err_orphan, 1);
    chk("orph_lwr", bus.local_write_req, 0);
    tick();

    // after reset port 0 wins first
    set_cmd(0, 1, 0, 0, 25'ha0, 3'd1, 32'h0);
    set_cmd(1, 1, 0, 0, 25'hb0, 3'd1, 32'h0);
    tick();
    #1;
    chk("rst_first_p0", bus.port_ready, 1);
    exp_q.push_back(0);
    tick();
    set_cmd(0, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    set_cmd(1, 0, 0, 0, 25'h0, 3'h0, 32'h0);
    ret_beat("ret_last");
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
